// File: rtl/score_pkg.sv
// Shared definitions for the multi-channel score renderer.
// Contents:
//   - display bus widths (pixel x/y, RGB)
//   - glyph geometry constants
//   - 3x5 font ROM, per-channel colours and default x positions
//   - BCD helpers: bcd_inc() for counting, dec_to_bcd() for constants
package score_pkg;

  localparam int unsigned X_POS_W     = 10;
  localparam int unsigned Y_POS_W     = 10;
  localparam int unsigned VGA_RGB_W   = 12;

  localparam int unsigned GLYPH_W     = 3;
  localparam int unsigned GLYPH_H     = 5;
  localparam int unsigned PITCH_CELLS = 4;

  // Widest BCD value the helpers handle; counters use the low DIGITS nibbles.
  localparam int unsigned MAX_DIGITS  = 8;

  typedef logic [3:0]              bcd_t;
  typedef logic [MAX_DIGITS*4-1:0] bcd_vec_t;

  // Glyph rows, top row in bits [14:12].
  // Within a row the MSB is the leftmost cell.
  localparam logic [14:0] FONT_3X5 [10] = '{
    15'b111_101_101_101_111,  // 0
    15'b010_110_010_010_111,  // 1
    15'b111_001_111_100_111,  // 2
    15'b111_001_111_001_111,  // 3
    15'b101_101_111_001_001,  // 4
    15'b111_100_111_001_111,  // 5
    15'b111_100_111_101_111,  // 6
    15'b111_001_001_001_001,  // 7
    15'b111_101_111_101_111,  // 8
    15'b111_101_111_001_111   // 9
  };

  localparam logic [VGA_RGB_W-1:0] CH_COLOR    [2] = '{12'h0FF, 12'hFF0};
  localparam logic [X_POS_W-1:0]   SCORE_X_POS [2] = '{10'd64, 10'd448};

  // Add one to the low ndig BCD digits.
  // Carry ripples upward; a carry out of the top digit is dropped, so all-9s wraps to 0.
  function automatic bcd_vec_t bcd_inc(input bcd_vec_t v, input int unsigned ndig);
    bcd_vec_t r;
    logic     carry;
    bcd_t     dig;
    r     = v;
    carry = 1'b1;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      dig          = v[i*4 +: 4];
      r[i*4 +: 4]  = (i < ndig && carry) ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
      carry        = (i < ndig) && carry && (dig == 4'd9);
    end
    return r;
  endfunction

  // Elaboration-time conversion of a decimal constant to packed BCD.
  function automatic bcd_vec_t dec_to_bcd(input int unsigned v);
    bcd_vec_t    r;
    int unsigned rem;
    rem = v;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      r[i*4 +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// One channel's BCD score register.
// Ports:
//   clk_i, rst_ni  clock, synchronous active-low reset
//   inc_i          add one point (caller already gates frozen channels)
//   clr_i          zero the score; wins over inc_i
//   value_o        registered packed BCD score, MS digit in the MSBs
//   eq_win_o       current score equals WIN_SCORE
module bcd_counter
  import score_pkg::*;
#(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned WIN_SCORE = 11
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  inc_i,
  input  logic                  clr_i,
  output logic [DIGITS*4-1:0]   value_o,
  output logic                  eq_win_o
);

  localparam bcd_vec_t             WIN_FULL = dec_to_bcd(WIN_SCORE);
  localparam logic [DIGITS*4-1:0]  WIN_BCD  = WIN_FULL[DIGITS*4-1:0];

  logic [DIGITS*4-1:0] value_q, value_d;
  bcd_vec_t            inc_full_s;
  logic                unused_inc_s;

  // Next score: clear, increment or hold.
  always_comb begin
    inc_full_s = bcd_inc(bcd_vec_t'(value_q), DIGITS);
    if (clr_i) begin
      value_d = '0;
    end else if (inc_i) begin
      value_d = inc_full_s[DIGITS*4-1:0];
    end else begin
      value_d = value_q;
    end
  end

  assign unused_inc_s = ^inc_full_s;

  // Score register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o  = value_q;
  assign eq_win_o = (value_q == WIN_BCD);

endmodule

// File: rtl/score_display_mc.sv
// Multi-channel score keeper and glyph renderer for the VGA pixel pipeline.
// Ports:
//   clk_i, rst_ni   pixel clock, synchronous active-low reset
//   pixel_x_i/y_i   current pixel coordinate
//   frame_tick_i    one pulse per frame; steps the blink counters
//   inc_i           per-channel point pulse
//   clear_i         new match: zero scores, blink counters, win flags
//   on_score_o      pixel is a lit glyph cell (2-cycle latency)
//   vga_rgb_o       channel colour for a lit cell, zero otherwise
//   win_o           sticky per-channel win flag
//   score_bcd_o     packed BCD scores, channel 0 in the LSBs
module score_display_mc
  import score_pkg::*;
#(
  parameter int unsigned           NUM_CH       = 2,
  parameter int unsigned           DIGITS       = 2,
  parameter int unsigned           SCALE_LOG2   = 3,
  parameter int unsigned           WIN_SCORE    = 11,
  parameter int unsigned           BLINK_FRAMES = 60,
  parameter int unsigned           BLINK_BIT    = 3,
  parameter logic [X_POS_W-1:0]    X_POS [NUM_CH] = SCORE_X_POS,
  parameter logic [Y_POS_W-1:0]    Y_POS        = 10'd32,
  parameter logic [VGA_RGB_W-1:0]  COLOR [NUM_CH] = CH_COLOR
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [X_POS_W-1:0]          pixel_x_i,
  input  logic [Y_POS_W-1:0]          pixel_y_i,
  input  logic                        frame_tick_i,
  input  logic [NUM_CH-1:0]           inc_i,
  input  logic                        clear_i,
  output logic                        on_score_o,
  output logic [VGA_RGB_W-1:0]        vga_rgb_o,
  output logic [NUM_CH-1:0]           win_o,
  output logic [NUM_CH*DIGITS*4-1:0]  score_bcd_o
);

  localparam int unsigned BOX_W  = DIGITS * PITCH_CELLS * (1 << SCALE_LOG2);
  localparam int unsigned BOX_H  = GLYPH_H * (1 << SCALE_LOG2);
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned BC_W_A = $clog2(BLINK_FRAMES + 1);
  localparam int unsigned BC_W   = (BC_W_A > BLINK_BIT + 1) ? BC_W_A : BLINK_BIT + 1;

  localparam logic [BC_W-1:0] BLINK_LOAD = BLINK_FRAMES[BC_W-1:0];
  localparam logic [BC_W-1:0] BLINK_ONE  = {{(BC_W-1){1'b0}}, 1'b1};

  // One extra bit so box limits near the screen edge cannot wrap.
  typedef logic [X_POS_W:0] xw_t;
  typedef logic [Y_POS_W:0] yw_t;

  localparam yw_t Y_LO = yw_t'(Y_POS);
  localparam yw_t Y_HI = Y_LO + yw_t'(BOX_H);

  // Score state.
  logic [DIGITS*4-1:0] value_s  [NUM_CH];
  logic [NUM_CH-1:0]   eq_win_s;
  logic [NUM_CH-1:0]   inc_ok_s;
  logic [NUM_CH-1:0]   win_q, win_d;
  logic [BC_W-1:0]     blink_q  [NUM_CH];
  logic [BC_W-1:0]     blink_d  [NUM_CH];
  logic [NUM_CH-1:0]   hidden_s;

  // Stage-1 per-channel geometry.
  logic [NUM_CH-1:0]   hit_s;
  logic [3:0]          nib_s    [NUM_CH];
  logic [1:0]          col_s    [NUM_CH];
  logic [Y_POS_W-1:0]  dy_s;
  logic [2:0]          row_s;
  logic                y_in_s;
  logic                unused_dy_s;

  // Stage-1 register and its next state.
  logic                s1_hit_q, s1_hit_d;
  logic [CH_W-1:0]     s1_ch_q,  s1_ch_d;
  logic [3:0]          s1_nib_q, s1_nib_d;
  logic [1:0]          s1_col_q, s1_col_d;
  logic [2:0]          s1_row_q, s1_row_d;

  // Stage-2 (output) register and its next state.
  logic                on_q,  on_d;
  logic [VGA_RGB_W-1:0] rgb_q, rgb_d;
  logic [14:0]         glyph_s;
  logic [3:0]          bit_idx_s;

  assign dy_s        = pixel_y_i - Y_POS;
  assign row_s       = dy_s[SCALE_LOG2 +: 3];
  assign y_in_s      = (yw_t'(pixel_y_i) >= Y_LO) && (yw_t'(pixel_y_i) < Y_HI);
  assign unused_dy_s = ^dy_s;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    localparam xw_t X_LO = xw_t'(X_POS[c]);
    localparam xw_t X_HI = X_LO + xw_t'(BOX_W);

    logic [X_POS_W-1:0] dx_s;
    logic [DIG_W-1:0]   dig_s;
    logic [3:0]         nib_l;
    logic               x_in_s;
    logic               unused_dx_s;

    bcd_counter #(
      .DIGITS    (DIGITS),
      .WIN_SCORE (WIN_SCORE)
    ) u_cnt (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .inc_i    (inc_ok_s[c]),
      .clr_i    (clear_i),
      .value_o  (value_s[c]),
      .eq_win_o (eq_win_s[c])
    );

    // A channel sitting on WIN_SCORE is frozen even before its win flag lands.
    assign inc_ok_s[c] = inc_i[c] & ~win_q[c] & ~eq_win_s[c];

    assign dx_s        = pixel_x_i - X_POS[c];
    assign dig_s       = dx_s[SCALE_LOG2 + 2 +: DIG_W];
    assign col_s[c]    = dx_s[SCALE_LOG2 +: 2];
    assign x_in_s      = (xw_t'(pixel_x_i) >= X_LO) && (xw_t'(pixel_x_i) < X_HI);
    // Column 3 of every digit pitch is the inter-digit gap.
    assign hit_s[c]    = x_in_s & y_in_s & (col_s[c] != 2'd3);
    assign unused_dx_s = ^dx_s;

    // Digit 0 is leftmost, so it shows the most significant nibble.
    always_comb begin
      nib_l = 4'd0;
      for (int d = 0; d < DIGITS; d++) begin
        nib_l = (dig_s == DIG_W'(d)) ? value_s[c][(DIGITS-1-d)*4 +: 4] : nib_l;
      end
    end

    assign nib_s[c] = nib_l;
    assign score_bcd_o[c*DIGITS*4 +: DIGITS*4] = value_s[c];
  end

  // Win flags, blink counters and blink visibility.
  always_comb begin
    win_d = win_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (clear_i) begin
        win_d[c]   = 1'b0;
        blink_d[c] = '0;
      end else begin
        win_d[c] = win_q[c] | eq_win_s[c];
        // A fresh point reloads the counter even on a frame tick.
        if (inc_ok_s[c]) begin
          blink_d[c] = BLINK_LOAD;
        end else if (frame_tick_i && (blink_q[c] != '0)) begin
          blink_d[c] = blink_q[c] - BLINK_ONE;
        end else begin
          blink_d[c] = blink_q[c];
        end
      end
      hidden_s[c] = (blink_q[c] != '0) && blink_q[c][BLINK_BIT];
    end
  end

  // Stage 1: pick the hit channel; iterating downward lets the lowest index win.
  always_comb begin
    s1_hit_d = 1'b0;
    s1_ch_d  = '0;
    s1_nib_d = 4'd0;
    s1_col_d = 2'd0;
    s1_row_d = row_s;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (hit_s[c]) begin
        s1_hit_d = 1'b1;
        s1_ch_d  = CH_W'(c);
        s1_nib_d = nib_s[c];
        s1_col_d = col_s[c];
      end else begin
        s1_hit_d = s1_hit_d;
      end
    end
  end

  // Stage 2: font lookup (bit = 14 - (3*row + col), via shift-add), blink mask, colour.
  always_comb begin
    glyph_s   = (s1_nib_q <= 4'd9) ? FONT_3X5[s1_nib_q] : 15'd0;
    bit_idx_s = 4'd14 - ({s1_row_q, 1'b0} + {1'b0, s1_row_q}) - {2'b00, s1_col_q};
    on_d      = s1_hit_q & glyph_s[bit_idx_s] & ~hidden_s[s1_ch_q];
    if (on_d) begin
      rgb_d = COLOR[s1_ch_q];
    end else begin
      rgb_d = '0;
    end
  end

  // State, stage-1 and output registers; reset discards in-flight pixels.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      win_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        blink_q[c] <= '0;
      end
      s1_hit_q <= 1'b0;
      s1_ch_q  <= '0;
      s1_nib_q <= 4'd0;
      s1_col_q <= 2'd0;
      s1_row_q <= 3'd0;
      on_q     <= 1'b0;
      rgb_q    <= '0;
    end else begin
      win_q    <= win_d;
      blink_q  <= blink_d;
      s1_hit_q <= s1_hit_d;
      s1_ch_q  <= s1_ch_d;
      s1_nib_q <= s1_nib_d;
      s1_col_q <= s1_col_d;
      s1_row_q <= s1_row_d;
      on_q     <= on_d;
      rgb_q    <= rgb_d;
    end
  end

  assign on_score_o = on_q;
  assign vga_rgb_o  = rgb_q;
  assign win_o      = win_q;

endmodule
